// File: rtl/platform_pio_pkg.sv
// Shared definitions for the platform_* PIO peripherals: register addresses,
// edge-capture mode encodings and the debounce counter width helper.
package platform_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum int {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } edge_mode_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/platform_debounce.sv
// Single-channel synchroniser and debouncer; emits the debounced level and a
// one-cycle pulse on the selected edge in the cycle the level changes.
module platform_debounce
  import platform_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 1,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic deb,
  output logic edge_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   sync_bit, change, deb_next;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // The counter is cleared whenever the level agrees or the change commits, so it never wraps.
  always_comb begin
    change   = 1'b0;
    deb_next = deb;
    cnt_next = '0;
    if (sync_bit != deb) begin
      if (cnt == CNT_LAST) begin
        change   = 1'b1;
        deb_next = sync_bit;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    edge_pulse = 1'b0;
    if (EDGE_MODE == EDGE_RISING)       edge_pulse = change & sync_bit;
    else if (EDGE_MODE == EDGE_FALLING) edge_pulse = change & ~sync_bit;
    else                                edge_pulse = change;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      deb    <= RESET_LEVEL;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
      deb    <= deb_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/platform_button_irq.sv
// Avalon-MM button/switch PIO: debounced DATA, IRQMASK, write-1-to-clear
// EDGECAP and a registered level interrupt.
module platform_button_irq
  import platform_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 1,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb, edge_pulse, irq_mask, edge_cap, cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;
  assign wr_en            = chipselect & ~write_n;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    platform_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_bit    (in_port[g]),
      .deb       (deb[g]),
      .edge_pulse(edge_pulse[g])
    );
  end

  always_comb begin
    cap_clr = '0;
    if (wr_en && address == ADDR_EDGECAP) cap_clr = writedata[WIDTH-1:0];
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = deb;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      readdata <= rd_mux;
      irq      <= |(edge_cap & irq_mask);
      if (wr_en && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      // Pulse is OR-ed after the clear so a same-cycle capture survives.
      edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
    end
  end

endmodule
